// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_arb_pkg
// Purpose  : Shared state encoding and grant constants for wb_arbiter2.
// Revision : 1.0 - initial release
// ============================================================================
package wb_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GNT0 = 2'd1;
    localparam logic [1:0] ST_GNT1 = 2'd2;
    localparam logic [1:0] ST_TERM = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        GNT0 = ST_GNT0,
        GNT1 = ST_GNT1,
        TERM = ST_TERM
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/wb_arb_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : wb_arb_watchdog
// Purpose  : Counts unacknowledged strobe cycles; flags the last allowed one.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arb_watchdog #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam logic            c_enabled = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] c_last    = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [TO_W-1:0] r_count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (clr_i) begin
            r_count <= '0;
        end else if (en_i) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Fires in the cycle the count reaches its limit with ack still missing.
    assign expire_o = c_enabled && en_i && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/wb_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter2
// Purpose  : Two-master / one-slave Wishbone arbiter with registered grant
//            and a watchdog that aborts cycles the slave never acknowledges.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter2 #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 32,
    parameter int FIXED_PRI = 0,
    parameter int TIMEOUT   = 255,
    parameter int TO_W      = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [ADDR_W-1:0]   m0_adr_i,
    input  logic [DATA_W-1:0]   m0_dat_i,
    output logic [DATA_W-1:0]   m0_dat_o,
    input  logic [DATA_W/8-1:0] m0_sel_i,
    input  logic                m0_we_i,
    input  logic                m0_cyc_i,
    input  logic                m0_stb_i,
    output logic                m0_ack_o,
    output logic                m0_err_o,
    input  logic [ADDR_W-1:0]   m1_adr_i,
    input  logic [DATA_W-1:0]   m1_dat_i,
    output logic [DATA_W-1:0]   m1_dat_o,
    input  logic [DATA_W/8-1:0] m1_sel_i,
    input  logic                m1_we_i,
    input  logic                m1_cyc_i,
    input  logic                m1_stb_i,
    output logic                m1_ack_o,
    output logic                m1_err_o,
    output logic [ADDR_W-1:0]   s_adr_o,
    output logic [DATA_W-1:0]   s_dat_o,
    input  logic [DATA_W-1:0]   s_dat_i,
    output logic [DATA_W/8-1:0] s_sel_o,
    output logic                s_we_o,
    output logic                s_cyc_o,
    output logic                s_stb_o,
    input  logic                s_ack_i,
    output logic [1:0]          gnt_o
);

    import wb_arb_pkg::*;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_last;        // 0 = m0 held the most recent grant, 1 = m1
    logic   w_last_nxt;
    logic   r_err;
    logic   w_wd_en;
    logic   w_wd_clr;
    logic   w_expire;
    logic   w_owner_cyc;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_err   <= w_expire;
        end
    end

    assign w_owner_cyc = r_last ? m1_cyc_i : m0_cyc_i;

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        case (r_state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    // Round-robin hands the tie to whoever was not served last.
                    if ((FIXED_PRI != 0) || r_last) begin
                        w_state_nxt = GNT0;
                        w_last_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = GNT1;
                        w_last_nxt  = 1'b1;
                    end
                end else if (m0_cyc_i) begin
                    w_state_nxt = GNT0;
                    w_last_nxt  = 1'b0;
                end else if (m1_cyc_i) begin
                    w_state_nxt = GNT1;
                    w_last_nxt  = 1'b1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    w_state_nxt = IDLE;
                end else if (w_expire) begin
                    w_state_nxt = TERM;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    w_state_nxt = IDLE;
                end else if (w_expire) begin
                    w_state_nxt = TERM;
                end
            end
            TERM: begin
                if (!w_owner_cyc) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_dat_o = '0;
        m1_dat_o = '0;
        gnt_o    = GNT_NONE;
        case (r_state)
            GNT0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_we_o   = m0_we_i;
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                m0_ack_o = s_ack_i;
                m0_dat_o = s_dat_i;
                gnt_o    = GNT_M0;
            end
            GNT1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_we_o   = m1_we_i;
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                m1_ack_o = s_ack_i;
                m1_dat_o = s_dat_i;
                gnt_o    = GNT_M1;
            end
            // Slave side is already released; only the grant indication remains.
            TERM:    gnt_o = r_last ? GNT_M1 : GNT_M0;
            default: gnt_o = GNT_NONE;
        endcase
    end

    assign m0_err_o = r_err && !r_last;
    assign m1_err_o = r_err &&  r_last;

    assign w_wd_en  = ((r_state == GNT0) || (r_state == GNT1)) && s_stb_o && !s_ack_i;
    assign w_wd_clr = !w_wd_en;

    wb_arb_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (w_wd_en),
        .clr_i    (w_wd_clr),
        .expire_o (w_expire)
    );

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter2
// Purpose  : Directed vector bench for wb_arbiter2 (round-robin and fixed
//            priority instances driven from the same master/slave stimulus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] m0_adr = '0, m1_adr = '0;
    logic [15:0] m0_dat = '0, m1_dat = '0;
    logic [1:0]  m0_sel = 2'b11, m1_sel = 2'b01;
    logic        m0_we = 1'b0, m0_cyc = 1'b0, m0_stb = 1'b0;
    logic        m1_we = 1'b0, m1_cyc = 1'b0, m1_stb = 1'b0;
    logic [15:0] s_dat_i = '0;
    logic        s_ack = 1'b0;

    logic [15:0] m0_dat_o, m1_dat_o, s_dat_o;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] s_adr;
    logic [1:0]  s_sel, gnt;
    logic        s_we, s_cyc, s_stb;

    logic [15:0] fp_m0_dat_o, fp_m1_dat_o, fp_s_dat_o;
    logic        fp_m0_ack, fp_m0_err, fp_m1_ack, fp_m1_err;
    logic [31:0] fp_s_adr;
    logic [1:0]  fp_s_sel, fp_gnt;
    logic        fp_s_we, fp_s_cyc, fp_s_stb;

    always #5 clk = ~clk;

    wb_arbiter2 #(.DATA_W(16), .ADDR_W(32), .FIXED_PRI(0), .TIMEOUT(4), .TO_W(8)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(m0_dat_o), .m0_sel_i(m0_sel),
        .m0_we_i(m0_we), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(m1_dat_o), .m1_sel_i(m1_sel),
        .m1_we_i(m1_we), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_sel_o(s_sel), .s_we_o(s_we),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_ack_i(s_ack), .gnt_o(gnt)
    );

    wb_arbiter2 #(.DATA_W(16), .ADDR_W(32), .FIXED_PRI(1), .TIMEOUT(255), .TO_W(8)) u_dut_fp (
        .clk_i(clk), .rst_i(rst),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(fp_m0_dat_o), .m0_sel_i(m0_sel),
        .m0_we_i(m0_we), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_ack_o(fp_m0_ack), .m0_err_o(fp_m0_err),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(fp_m1_dat_o), .m1_sel_i(m1_sel),
        .m1_we_i(m1_we), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_ack_o(fp_m1_ack), .m1_err_o(fp_m1_err),
        .s_adr_o(fp_s_adr), .s_dat_o(fp_s_dat_o), .s_dat_i(s_dat_i), .s_sel_o(fp_s_sel), .s_we_o(fp_s_we),
        .s_cyc_o(fp_s_cyc), .s_stb_o(fp_s_stb), .s_ack_i(s_ack), .gnt_o(fp_gnt)
    );

    // exp = {gnt, fp_gnt, s_cyc,s_stb,s_we, s_adr, s_dat_o, s_sel, {m1_ack,m0_ack}, {m1_err,m0_err}, m0_dat_o, m1_dat_o}
    typedef struct {
        logic        rst;
        logic [2:0]  c0;   // {cyc, stb, we}
        logic [31:0] a0;
        logic [15:0] d0;
        logic [2:0]  c1;
        logic [31:0] a1;
        logic [15:0] d1;
        logic        ack;
        logic [15:0] sd;
        logic [92:0] exp;
    } vec_t;

    vec_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic vec_t mk(
        input logic rst, input logic [2:0] c0, input logic [31:0] a0, input logic [15:0] d0,
        input logic [2:0] c1, input logic [31:0] a1, input logic [15:0] d1,
        input logic ack, input logic [15:0] sd,
        input logic [1:0] g, input logic [1:0] gfp, input logic [2:0] sc, input logic [31:0] sa,
        input logic [15:0] sdo, input logic [1:0] ssel, input logic [1:0] acks, input logic [1:0] errs,
        input logic [15:0] m0do, input logic [15:0] m1do);
        vec_t v;
        v.rst = rst; v.c0 = c0; v.a0 = a0; v.d0 = d0;
        v.c1 = c1; v.a1 = a1; v.d1 = d1; v.ack = ack; v.sd = sd;
        v.exp = {g, gfp, sc, sa, sdo, ssel, acks, errs, m0do, m1do};
        return v;
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [92:0] observe();
        return {gnt, fp_gnt, s_cyc, s_stb, s_we, s_adr, s_dat_o, s_sel,
                m1_ack, m0_ack, m1_err, m0_err, m0_dat_o, m1_dat_o};
    endfunction

    initial begin
        // reset, then single-master read with one wait state
        q.push_back(mk(1, 3'b000, 0, 0, 3'b000, 0, 0, 0, 0,               2'b00, 2'b00, 3'b000, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        q.push_back(mk(0, 3'b110, 32'h1000, 0, 3'b000, 0, 0, 0, 0,        2'b00, 2'b00, 3'b000, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        q.push_back(mk(0, 3'b110, 32'h1000, 0, 3'b000, 0, 0, 0, 0,        2'b01, 2'b01, 3'b110, 32'h1000, 0, 2'b11, 2'b00, 2'b00, 0, 0));
        q.push_back(mk(0, 3'b110, 32'h1000, 0, 3'b000, 0, 0, 1, 16'hBEEF, 2'b01, 2'b01, 3'b110, 32'h1000, 0, 2'b11, 2'b01, 2'b00, 16'hBEEF, 0));
        q.push_back(mk(0, 3'b000, 0, 0, 3'b000, 0, 0, 0, 0,               2'b01, 2'b01, 3'b000, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0));
        q.push_back(mk(0, 3'b000, 0, 0, 3'b000, 0, 0, 0, 0,               2'b00, 2'b00, 3'b000, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        // simultaneous request after reset: m0 first, one idle cycle, then m1
        q.push_back(mk(1, 3'b000, 0, 0, 3'b000, 0, 0, 0, 0,               2'b00, 2'b00, 3'b000, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        q.push_back(mk(0, 3'b111, 32'h1000_0000, 16'h1234, 3'b110, 32'h3000_0004, 16'h5555, 0, 0, 2'b00, 2'b00, 3'b000, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        q.push_back(mk(0, 3'b111, 32'h1000_0000, 16'h1234, 3'b110, 32'h3000_0004, 16'h5555, 0, 0, 2'b01, 2'b01, 3'b111, 32'h1000_0000, 16'h1234, 2'b11, 2'b00, 2'b00, 0, 0));
        q.push_back(mk(0, 3'b111, 32'h1000_0000, 16'h1234, 3'b110, 32'h3000_0004, 16'h5555, 1, 16'hC0DE, 2'b01, 2'b01, 3'b111, 32'h1000_0000, 16'h1234, 2'b11, 2'b01, 2'b00, 16'hC0DE, 0));
        q.push_back(mk(0, 3'b000, 0, 0, 3'b110, 32'h3000_0004, 16'h5555, 0, 0, 2'b01, 2'b01, 3'b000, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0));
        q.push_back(mk(0, 3'b000, 0, 0, 3'b110, 32'h3000_0004, 16'h5555, 0, 0, 2'b00, 2'b00, 3'b000, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        q.push_back(mk(0, 3'b000, 0, 0, 3'b110, 32'h3000_0004, 16'h5555, 0, 0, 2'b10, 2'b10, 3'b110, 32'h3000_0004, 16'h5555, 2'b01, 2'b00, 2'b00, 0, 0));
        q.push_back(mk(0, 3'b000, 0, 0, 3'b110, 32'h3000_0004, 16'h5555, 1, 16'hA5A5, 2'b10, 2'b10, 3'b110, 32'h3000_0004, 16'h5555, 2'b01, 2'b10, 2'b00, 0, 16'hA5A5));
        q.push_back(mk(0, 3'b000, 0, 0, 3'b000, 0, 0, 0, 0,               2'b10, 2'b10, 3'b000, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0));
        // fairness: m0 re-requests right after release while m1 waits
        q.push_back(mk(0, 3'b110, 32'h2000, 0, 3'b110, 32'h3000_0008, 0, 0, 0,        2'b00, 2'b00, 3'b000, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        q.push_back(mk(0, 3'b110, 32'h2000, 0, 3'b110, 32'h3000_0008, 0, 1, 16'h0F0F, 2'b01, 2'b01, 3'b110, 32'h2000, 0, 2'b11, 2'b01, 2'b00, 16'h0F0F, 0));
        q.push_back(mk(0, 3'b000, 0, 0, 3'b110, 32'h3000_0008, 0, 0, 0,               2'b01, 2'b01, 3'b000, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0));
        q.push_back(mk(0, 3'b110, 32'h2000, 0, 3'b110, 32'h3000_0008, 0, 0, 0,        2'b00, 2'b00, 3'b000, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        q.push_back(mk(0, 3'b110, 32'h2000, 0, 3'b110, 32'h3000_0008, 0, 1, 16'h1111, 2'b10, 2'b01, 3'b110, 32'h3000_0008, 0, 2'b01, 2'b10, 2'b00, 0, 16'h1111));
        q.push_back(mk(0, 3'b110, 32'h2000, 0, 3'b000, 0, 0, 0, 0,                    2'b10, 2'b01, 3'b000, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0));
        // locked burst: m1 keeps cyc for 4 beats while m0 waits
        q.push_back(mk(1, 3'b000, 0, 0, 3'b000, 0, 0, 0, 0,               2'b00, 2'b00, 3'b000, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        q.push_back(mk(0, 3'b000, 0, 0, 3'b111, 32'hF000_0008, 16'h0001, 0, 0, 2'b00, 2'b00, 3'b000, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        for (int b = 1; b <= 4; b++) begin
            q.push_back(mk(0, 3'b110, 32'h3000, 0, 3'b111, 32'hF000_0008, 16'(b), 1, 16'h00B0 + 16'(b),
                           2'b10, 2'b10, 3'b111, 32'hF000_0008, 16'(b), 2'b01, 2'b10, 2'b00, 0, 16'h00B0 + 16'(b)));
        end
        q.push_back(mk(0, 3'b110, 32'h3000, 0, 3'b000, 0, 0, 0, 0,        2'b10, 2'b10, 3'b000, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0));
        q.push_back(mk(0, 3'b110, 32'h3000, 0, 3'b000, 0, 0, 0, 0,        2'b00, 2'b00, 3'b000, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        q.push_back(mk(0, 3'b110, 32'h3000, 0, 3'b000, 0, 0, 1, 16'h7777, 2'b01, 2'b01, 3'b110, 32'h3000, 0, 2'b11, 2'b01, 2'b00, 16'h7777, 0));
        q.push_back(mk(0, 3'b000, 0, 0, 3'b000, 0, 0, 0, 0,               2'b01, 2'b01, 3'b000, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0));
        // watchdog abort (TIMEOUT=4 on the round-robin instance)
        q.push_back(mk(1, 3'b000, 0, 0, 3'b000, 0, 0, 0, 0,               2'b00, 2'b00, 3'b000, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        q.push_back(mk(0, 3'b110, 32'h2000_0000, 0, 3'b000, 0, 0, 0, 0,   2'b00, 2'b00, 3'b000, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        for (int w = 0; w < 4; w++) begin
            q.push_back(mk(0, 3'b110, 32'h2000_0000, 0, 3'b000, 0, 0, 0, 0, 2'b01, 2'b01, 3'b110, 32'h2000_0000, 0, 2'b11, 2'b00, 2'b00, 0, 0));
        end
        q.push_back(mk(0, 3'b110, 32'h2000_0000, 0, 3'b000, 0, 0, 1, 16'hDEAD, 2'b01, 2'b01, 3'b000, 0, 0, 2'b00, 2'b00, 2'b01, 0, 0));
        q.push_back(mk(0, 3'b110, 32'h2000_0000, 0, 3'b000, 0, 0, 1, 16'hDEAD, 2'b01, 2'b01, 3'b000, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        q.push_back(mk(0, 3'b000, 0, 0, 3'b000, 0, 0, 0, 0,               2'b01, 2'b01, 3'b000, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        q.push_back(mk(0, 3'b000, 0, 0, 3'b000, 0, 0, 0, 0,               2'b00, 2'b00, 3'b000, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));

        foreach (q[i]) begin
            @(posedge clk); #1;
            rst    = q[i].rst;
            {m0_cyc, m0_stb, m0_we} = q[i].c0;
            m0_adr = q[i].a0; m0_dat = q[i].d0;
            {m1_cyc, m1_stb, m1_we} = q[i].c1;
            m1_adr = q[i].a1; m1_dat = q[i].d1;
            s_ack  = q[i].ack; s_dat_i = q[i].sd;
            @(negedge clk);
            check($sformatf("vec%0d", i), {3'b000, observe()}, {3'b000, q[i].exp});
        end

        // Reset asserted between edges while m1 owns the bus
        begin : mid_reset
            logic found;
            found = 1'b0;
            @(posedge clk); #1;
            m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h4000_0000;
            for (int k = 0; k < 5 && !found; k++) begin
                @(negedge clk);
                if (gnt == 2'b10) found = 1'b1;
            end
            check("mid_gnt1", {95'b0, found}, 96'd1);
            s_ack = 1'b1; s_dat_i = 16'h9999;
            #1;
            check("mid_ack_fwd", {79'b0, m1_ack, m1_dat_o}, {79'b0, 1'b1, 16'h9999});
            #1 rst = 1'b1;
            #1;
            check("mid_rst_clear", {76'b0, s_cyc, s_stb, gnt, m1_ack, m0_ack, m1_dat_o},
                  96'd0);
            @(posedge clk); #1;
            rst = 1'b0; s_ack = 1'b0; s_dat_i = '0;
            m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h5000;
            @(negedge clk);
            check("mid_idle", {94'b0, gnt}, 96'd0);
            @(negedge clk);
            check("mid_regrant", {60'b0, gnt, fp_gnt, s_adr}, {60'b0, 2'b01, 2'b01, 32'h5000});
            @(posedge clk); #1;
            m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
            repeat (2) @(posedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_arbiter2.md
Name: wb_arbiter2

Overview:
- Two-master, single-slave Wishbone arbiter placed between the bus masters and `wb_intercon`.
- Shares the SoC bus between the moxie core (m0) and a second master (m1, the planned DMA/debug loader).
- The granted master's signals pass through combinationally. The arbitration decision is registered.
- A watchdog terminates slave cycles that never acknowledge, so an unmapped address cannot hang the bus.

Parameters:
- DATA_W, 16, data bus width; sel width is DATA_W/8.
- ADDR_W, 32, address width.
- FIXED_PRI, 0: 0 = round-robin; 1 = m0 always wins ties.
- TIMEOUT, 255: cycles with stb high and no ack before abort; 0 disables the watchdog.
- TO_W, 8: watchdog counter width; must satisfy 2^TO_W > TIMEOUT.

Ports (mN_ denotes one identical port each for N=0 and N=1):
- clk_i  in  1  clock
- rst_i  in  1  reset
- mN_adr_i  in  ADDR_W  master address
- mN_dat_i  in  DATA_W  master write data
- mN_dat_o  out  DATA_W  read data to master
- mN_sel_i  in  DATA_W/8  byte selects
- mN_we_i  in  1  write enable
- mN_cyc_i  in  1  cycle request
- mN_stb_i  in  1  strobe
- mN_ack_o  out  1  acknowledge
- mN_err_o  out  1  watchdog abort, single-cycle pulse
- s_adr_o  out  ADDR_W  to intercon
- s_dat_o  out  DATA_W  to intercon
- s_dat_i  in  DATA_W  from intercon
- s_sel_o  out  DATA_W/8  to intercon
- s_we_o  out  1  to intercon
- s_cyc_o  out  1  to intercon
- s_stb_o  out  1  to intercon
- s_ack_i  in  1  from intercon
- gnt_o  out  2  one-hot current grant; 00 = none

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset state: state=IDLE, last=1 (so m0 wins the first tie), watchdog count=0.
- Reset output values: all s_* =0, mN_ack_o=0, mN_err_o=0, gnt_o=00, mN_dat_o=0.
- FSM states: IDLE, GNT0, GNT1, TERM.
- IDLE:
  - No slave signals are driven (s_cyc_o=s_stb_o=0).
  - At the clock edge, sample m0_cyc_i and m1_cyc_i.
  - Only one master requesting: go to its GNTn.
  - Both requesting, FIXED_PRI=1: go to GNT0.
  - Both requesting, FIXED_PRI=0: grant the master that is not `last`.
  - On any grant, last <= granted master.
- Grant latency: a master raising cyc in cycle k sees s_cyc_o in cycle k+1 at the earliest.
- GNTn:
  - s_adr/dat/sel/we/cyc/stb follow master n combinationally.
  - mn_ack_o = s_ack_i.
  - mn_dat_o = s_dat_i; the other master's dat_o = 0.
  - The other master sees ack=0 and err=0 and keeps waiting.
  - Multiple stb/ack beats are allowed while mn_cyc_i stays high. The grant is held, which provides bus locking.
- Release: mn_cyc_i low in GNTn -> IDLE at the next edge. s_cyc_o drops in that same cycle because it is combinational. There is always one idle cycle between grants, so back-to-back handoff takes 2 cycles.
- Watchdog:
  - Increments on each GNTn cycle where s_stb_o=1 and s_ack_i=0.
  - Clears on s_ack_i, on stb low, and in IDLE.
  - When count==TIMEOUT-1 and ack is still absent: pulse mn_err_o for the next cycle and move to TERM.
  - TIMEOUT=0: the counter never fires.
- TERM:
  - s_cyc_o=s_stb_o=0.
  - A late s_ack_i is ignored and never forwarded.
  - The holding master's ack_o is forced 0. err_o is high only for the first TERM cycle.
  - Remain in TERM until the owning mn_cyc_i goes low, then go to IDLE.
  - gnt_o stays one-hot at the owner while in TERM.
- Master drops cyc with ack pending: the transfer is abandoned and the intercon sees cyc low immediately. No error is raised.
- Reset asserted mid-cycle: outputs clear asynchronously. The in-flight transfer is lost; both masters must restart.
- The arbiter never reorders or buffers data. Its only storage is the FSM, `last`, and the watchdog counter.

Decomposition:
- Package wb_arb_pkg holds:
  - the state encoding localparams (IDLE=2'd0, GNT0=2'd1, GNT1=2'd2, TERM=2'd3);
  - the GNT_NONE/GNT_M0/GNT_M1 constants.
- Sub-module wb_arb_watchdog (params TIMEOUT, TO_W; ports clk_i, rst_i, en_i, clr_i, expire_o) holds the counter.
- The FSM and the muxing stay in wb_arbiter2.

Test Plan:
- Single master: m0 reads 0x00001000, slave acks after 1 wait state with 0xBEEF -> s_cyc_o high from cycle k+1; m0_dat_o=0xBEEF with m0_ack_o; gnt_o=01; m1_ack_o stays 0.
- Simultaneous request after reset, FIXED_PRI=0: m0 granted first and writes 0x1234 to 0x10000000 -> after m0 drops cyc, 1 idle cycle, then gnt_o=10; m1 transfer completes.
- Fairness: m0 reissues cyc on the cycle right after release while m1 waits -> m1 is granted next. With FIXED_PRI=1 the same stimulus grants m0 again.
- Locked burst: m1 holds cyc across 4 stb/ack beats to 0xF0000008 while m0 requests -> gnt_o stays 10 for all 4 beats; m0 is granted only after m1 drops cyc.
- Timeout: TIMEOUT=4, m0 accesses 0x20000000 (slave never acks) -> m0_err_o pulses exactly once, 4 cycles after stb; s_cyc_o=0 next cycle; an injected late ack is not forwarded; return to IDLE after m0 drops cyc.
- Reset mid-transfer: assert rst_i between clock edges during GNT1 -> s_cyc_o, gnt_o and ack outputs go to 0 immediately. After release, simultaneous requests grant m0 first.
